// File: rtl/ct_f_spsram_1024x59_ctrl.sv
// Request/response front end for the 1024x59 single-port SRAM: power-up clear,
// valid/ready requests mapped to CEN/GWEN/WEN, reads returned through a 3-entry FIFO.
module ct_f_spsram_1024x59_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 59,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    // state   | meaning
    // ST_INIT | writing INIT_VALUE to every address, requests blocked
    // ST_RUN  | serving requests
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic                    inflight;
    logic [1:0]              fifo_cnt;
    logic [1:0]              wr_ptr;
    logic [1:0]              rd_ptr;
    logic [DATA_WIDTH-1:0]   fifo_mem [0:2];
    logic [2:0]              occupancy;
    logic                    req_fire;
    logic                    rd_fire;
    logic                    push;
    logic                    pop;

    // Read admission looks only at registered occupancy, keeping rsp_rdy off the req_rdy path.
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight};
    assign req_rdy   = (state == ST_RUN) && (req_wr || (occupancy < 3'd3));
    assign req_fire  = req_vld && req_rdy;
    assign rd_fire   = req_fire && !req_wr;
    assign push      = inflight;
    assign rsp_vld   = (fifo_cnt != 2'd0);
    assign pop       = rsp_vld && rsp_rdy;
    assign rsp_rdata = fifo_mem[rd_ptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + ADDR_ONE;
                    if (&init_cnt) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN:  init_done <= 1'b1;
                default: state <= ST_INIT;
            endcase
        end
    end

    // SRAM pins stay idle while RST is held, even though the state already reads INIT.
    always_comb begin
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
        A    = req_addr;
        D    = req_wdata;
        if (RST) begin
            A = '0;
            D = '0;
        end else if (state == ST_INIT) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
            A    = init_cnt;
            D    = INIT_VALUE;
        end else if (req_fire) begin
            CEN = 1'b0;
            if (req_wr) begin
                GWEN = 1'b0;
                WEN  = ~req_wmask;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inflight <= 1'b0;
            fifo_cnt <= 2'd0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            inflight <= rd_fire;
            if (push) begin
                fifo_mem[wr_ptr] <= Q;
                wr_ptr           <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_1024x59_ctrl.sv
// Bench for ct_f_spsram_1024x59_ctrl: behavioural SRAM, word-level reference memory
// and an in-order expected-response queue.
module tb_ct_f_spsram_1024x59_ctrl;

    localparam int AW = 10;
    localparam int DW = 59;
    localparam logic [DW-1:0] MASK_PAT = 59'h400_0000_1FFF_FFFF;
    localparam logic [DW-1:0] ALL_ONES = 59'h7FF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] req_wmask = '0;
    logic          rsp_vld;
    logic          rsp_rdy = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] a;
    logic          cen;
    logic          gwen;
    logic [DW-1:0] wen;
    logic [DW-1:0] d;
    logic [DW-1:0] q = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rsp    = 0;

    logic [DW-1:0] sram    [1024];
    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] exp_q   [$];
    logic [DW-1:0] exp_data;
    logic [DW-1:0] last_rdata = '0;

    ct_f_spsram_1024x59_ctrl dut (
        .CLK       (clk),
        .RST       (rst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .A         (a),
        .CEN       (cen),
        .GWEN      (gwen),
        .WEN       (wen),
        .D         (d),
        .Q         (q)
    );

    always #5 clk = ~clk;

    // Single-port SRAM: bitwise write via active-low WEN, registered read data.
    always @(posedge clk) begin
        if (cen === 1'b0) begin
            if (gwen === 1'b0) sram[a] <= (sram[a] & wen) | (d & ~wen);
            else               q <= sram[a];
        end
    end

    // Every popped response must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rsp_vld === 1'b1 && rsp_rdy === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_rdata=%h with no read outstanding", rsp_rdata);
            end else begin
                exp_data = exp_q.pop_front();
                if (rsp_rdata !== exp_data) begin
                    n_fail++;
                    $display("FAIL rsp_data: got %h expected %h", rsp_rdata, exp_data);
                end
                last_rdata = rsp_rdata;
                n_rsp++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] wmask,
                        output int stalls);
        stalls    = 0;
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        @(negedge clk);
        while (req_rdy !== 1'b1 && stalls < 64) begin
            stalls++;
            @(negedge clk);
        end
        if (req_rdy !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: req_rdy=%b after %0d cycles, expected 1", req_rdy, stalls);
        end else if (wr) begin
            ref_mem[addr] = (ref_mem[addr] & ~wmask) | (wdata & wmask);
        end else begin
            exp_q.push_back(ref_mem[addr]);
        end
        @(posedge clk);
        #1;
        req_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses still outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst     = 1'b1;
        req_vld = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({req_rdy, rsp_vld, init_done, cen, gwen} !== 5'b00011) begin
            n_fail++;
            $display("FAIL reset_ctrl: req_rdy,rsp_vld,init_done,CEN,GWEN=%b expected 00011",
                     {req_rdy, rsp_vld, init_done, cen, gwen});
        end
        n_checks++;
        if (wen !== ALL_ONES || a !== '0 || d !== '0 || rsp_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: WEN=%h A=%h D=%h rsp_rdata=%h expected WEN all ones, others 0",
                     wen, a, d, rsp_rdata);
        end
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        exp_q.delete();
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            n_checks++;
            if (cen !== 1'b0 || gwen !== 1'b0 || wen !== '0 || a !== 10'(k) || d !== '0 ||
                init_done !== 1'b0 || req_rdy !== 1'b0) begin
                n_fail++;
                if (bad < 5)
                    $display("FAIL init_seq: cycle %0d CEN=%b GWEN=%b A=%0d D=%h init_done=%b req_rdy=%b expected 0,0,%0d,0,0,0",
                             k, cen, gwen, a, d, init_done, req_rdy, k);
                bad++;
            end
        end
        @(negedge clk);
        n_checks++;
        if (init_done !== 1'b1 || req_rdy !== 1'b1 || cen !== 1'b1) begin
            n_fail++;
            $display("FAIL init_end: init_done=%b req_rdy=%b CEN=%b expected 1,1,1", init_done, req_rdy, cen);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read_max();
        int s;
        rsp_rdy = 1'b0;
        send(1'b1, 10'h3FF, ALL_ONES, ALL_ONES, s);
        send(1'b0, 10'h3FF, '0, '0, s);
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_t1: rsp_vld=%b one cycle after accept, expected 0", rsp_vld);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== ALL_ONES) begin
            n_fail++;
            $display("FAIL lat_t2: rsp_vld=%b rsp_rdata=%h expected 1 and %h", rsp_vld, rsp_rdata, ALL_ONES);
        end
        @(posedge clk);
        #1;
        rsp_rdy = 1'b1;
        wait_drain();
    endtask

    task automatic test_write_mask();
        int s;
        rsp_rdy = 1'b1;
        send(1'b1, 10'd5, '0, ALL_ONES, s);
        send(1'b1, 10'd5, ALL_ONES, MASK_PAT, s);
        send(1'b0, 10'd5, '0, '0, s);
        wait_drain();
        n_checks++;
        if (last_rdata !== MASK_PAT) begin
            n_fail++;
            $display("FAIL write_mask: got %h expected %h", last_rdata, MASK_PAT);
        end
    endtask

    task automatic test_backpressure();
        int s;
        rsp_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) send(1'b1, 10'(i), {$urandom, $urandom}, ALL_ONES, s);
        rsp_rdy = 1'b0;
        req_vld = 1'b1;
        req_wr  = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            req_addr = 10'(i);
            @(negedge clk);
            n_checks++;
            if (req_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_accept: read %0d req_rdy=%b expected 1", i, req_rdy);
            end else begin
                exp_q.push_back(ref_mem[i]);
            end
            @(posedge clk);
            #1;
        end
        req_addr = 10'd4;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (req_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_full: cycle %0d req_rdy=%b expected 0", c, req_rdy);
            end
            @(posedge clk);
            #1;
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pop_cycle: req_rdy=%b expected 0", req_rdy);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_refill: req_rdy=%b expected 1", req_rdy);
        end else begin
            exp_q.push_back(ref_mem[4]);
        end
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int s;
        int reads = 0;
        int stall_total = 0;
        int rsp_start;
        rsp_rdy = 1'b1;
        for (int i = 100; i < 164; i++) send(1'b1, 10'(i), {$urandom, $urandom}, ALL_ONES, s);
        rsp_start = n_rsp;
        while (reads < 100) begin
            if ($urandom_range(0, 2) == 0) begin
                send(1'b1, 10'(500 + $urandom_range(0, 63)), {$urandom, $urandom}, {$urandom, $urandom}, s);
            end else begin
                send(1'b0, 10'(100 + $urandom_range(0, 63)), '0, '0, s);
                reads++;
            end
            stall_total += s;
        end
        n_checks++;
        if (stall_total != 0) begin
            n_fail++;
            $display("FAIL b2b_stall: %0d stall cycles, expected 0", stall_total);
        end
        wait_drain();
        n_checks++;
        if (n_rsp - rsp_start != 100) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses expected 100", n_rsp - rsp_start);
        end
    endtask

    task automatic test_reset_mid_op();
        int s;
        rsp_rdy = 1'b0;
        send(1'b1, 10'd7, {$urandom, $urandom}, ALL_ONES, s);
        send(1'b0, 10'd7, '0, '0, s);
        send(1'b0, 10'h3FF, '0, '0, s);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: rsp_vld=%b with 2 queued, expected 1", rsp_vld);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_vld !== 1'b0 || cen !== 1'b1 || req_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_immediate: rsp_vld=%b CEN=%b req_rdy=%b expected 0,1,0", rsp_vld, cen, req_rdy);
        end
        exp_q.delete();
        test_reset();
        rsp_rdy = 1'b1;
        send(1'b0, 10'h3FF, '0, '0, s);
        send(1'b0, 10'd7, '0, '0, s);
        wait_drain();
        n_checks++;
        if (last_rdata !== '0) begin
            n_fail++;
            $display("FAIL rst_reinit: got %h expected 0", last_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = {$urandom, $urandom};
        test_reset();
        test_write_read_max();
        test_write_mask();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
